// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 command codes and power-up init sequence for lcd_ctrl
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_PWR,
        ST_INIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
    localparam logic [7:0] LCD_CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY_INC = 8'h06;

    localparam int LCD_INIT_LEN = 4;
    localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{
        LCD_CMD_FUNC_8B2L, LCD_CMD_DISP_ON, LCD_CMD_CLEAR, LCD_CMD_ENTRY_INC
    };

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and home are the only instructions that need the long execution wait.
    function automatic logic lcd_is_long(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter; done while the count sits at zero
module lcd_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Load wins over counting; the counter parks at zero until reloaded.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 write-cycle sequencer behind a valid/ready byte port; define LCD_INIT_EN for built-in power-up init
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 2,
    parameter int EN_CYC       = 12,
    parameter int HOLD_CYC     = 2,
    parameter int CMD_WAIT_CYC = 1850,
    parameter int CLR_WAIT_CYC = 76000,
    parameter int PWR_WAIT_CYC = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    input  logic       i_lcd_on,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_busy
);

    localparam int MAX_CYC = lcd_max(lcd_max(lcd_max(SETUP_CYC, EN_CYC), lcd_max(HOLD_CYC, CMD_WAIT_CYC)),
                                     lcd_max(CLR_WAIT_CYC, PWR_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);
`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(PWR_WAIT_CYC - 1);
`endif

    lcd_state_e       state;
    logic             ready_q;
    logic             wait_long;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
`ifdef LCD_INIT_EN
    logic [2:0]       init_idx;
    logic             init_more;
    assign init_more = (init_idx < 3'(LCD_INIT_LEN));
`endif

    assign accept      = i_cmd_valid && ready_q;
    assign o_cmd_ready = ready_q;
    assign o_busy      = ~ready_q;
    assign o_lcd_rw    = 1'b0;

    lcd_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (i_clk),
        .resetn   (i_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Reload the timer with N-1 on the edge that enters each timed state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE:  if (accept)   begin tmr_load = 1'b1; tmr_val = SETUP_LD; end
            ST_SETUP: if (tmr_done) begin tmr_load = 1'b1; tmr_val = EN_LD;    end
            ST_PULSE: if (tmr_done) begin tmr_load = 1'b1; tmr_val = HOLD_LD;  end
            ST_HOLD:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = wait_long ? CLR_LD : CMD_LD; end
`ifdef LCD_INIT_EN
            ST_INIT:  begin tmr_load = 1'b1; tmr_val = PWR_LD; end
            ST_PWR:   if (tmr_done) begin tmr_load = 1'b1; tmr_val = SETUP_LD; end
            ST_WAIT:  if (tmr_done && init_more) begin tmr_load = 1'b1; tmr_val = SETUP_LD; end
`endif
            default:  ;
        endcase
    end

    // Bus sequencer: RS/DATA change only when a byte is taken, EN is a registered pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
`ifdef LCD_INIT_EN
            state    <= ST_INIT;
            init_idx <= '0;
`else
            state    <= ST_IDLE;
`endif
            ready_q    <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_lcd_en   <= 1'b0;
            wait_long  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_lcd_rs   <= i_cmd_rs;
                        o_lcd_data <= i_cmd_data;
                        wait_long  <= lcd_is_long(i_cmd_rs, i_cmd_data);
                        ready_q    <= 1'b0;
                        state      <= ST_SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        o_lcd_en <= 1'b1;
                        state    <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_done) begin
                        o_lcd_en <= 1'b0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tmr_done) begin
`ifdef LCD_INIT_EN
                        if (init_more) begin
                            o_lcd_rs   <= 1'b0;
                            o_lcd_data <= LCD_INIT_SEQ[init_idx[1:0]];
                            wait_long  <= lcd_is_long(1'b0, LCD_INIT_SEQ[init_idx[1:0]]);
                            init_idx   <= init_idx + 3'd1;
                            state      <= ST_SETUP;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= ST_IDLE;
                        end
`else
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
`endif
                    end
                end
`ifdef LCD_INIT_EN
                // First cycle out of reset only arms the power-up wait.
                ST_INIT: begin
                    state <= ST_PWR;
                end
                ST_PWR: begin
                    if (tmr_done) begin
                        o_lcd_rs   <= 1'b0;
                        o_lcd_data <= LCD_INIT_SEQ[0];
                        wait_long  <= lcd_is_long(1'b0, LCD_INIT_SEQ[0]);
                        init_idx   <= 3'd1;
                        state      <= ST_SETUP;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Backlight/power request is just retimed, independent of the sequencer.
    always_ff @(posedge i_clk) begin
        if (!i_rst) o_lcd_on <= 1'b0;
        else        o_lcd_on <= i_lcd_on;
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl with table, random and corner-case sequences
module tb_lcd_ctrl;

    localparam int SETUP = 2;
    localparam int ENC   = 4;
    localparam int HOLD  = 2;
    localparam int CMDW  = 10;
    localparam int CLRW  = 40;
    localparam int PWRW  = 20;

    logic       clk = 1'b0;
    logic       i_rst, i_cmd_valid, i_cmd_rs, i_lcd_on;
    logic [7:0] i_cmd_data;
    logic       o_cmd_ready, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy;
    logic [7:0] o_lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD),
        .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW), .PWR_WAIT_CYC(PWRW)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_rs(i_cmd_rs), .i_cmd_data(i_cmd_data), .i_lcd_on(i_lcd_on),
        .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_busy(o_busy)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         busy;
        int         en_first;
        int         en_len;
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: a byte costs the three bus phases plus its execution wait.
    function automatic int model_busy(input logic rs, input logic [7:0] d);
        return SETUP + ENC + HOLD + ((!rs && (d == 8'h01 || d == 8'h02)) ? CLRW : CMDW);
    endfunction

    // Called at a negedge while reset is asserted; releases it and waits for ready.
    task automatic release_and_wait();
        int         c;
        int         first_rise;
        logic       prev_en;
        logic [7:0] seen [$];
        logic [7:0] exp_seq [4];
        first_rise = -1;
        prev_en    = 1'b0;
        exp_seq    = '{8'h38, 8'h0C, 8'h01, 8'h06};
        chk("rst_ready", o_cmd_ready, 0);
        chk("rst_busy",  o_busy, 1);
        chk("rst_en",    o_lcd_en, 0);
        chk("rst_data",  o_lcd_data, 0);
        chk("rst_rs",    o_lcd_rs, 0);
        chk("rst_rw",    o_lcd_rw, 0);
        chk("rst_on",    o_lcd_on, 0);
        i_rst = 1'b1;
        for (c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (o_cmd_ready) break;
            if (o_lcd_en && !prev_en) begin
                seen.push_back(o_lcd_data);
                if (first_rise < 0) first_rise = c;
                chk("init_rs", o_lcd_rs, 0);
            end
            prev_en = o_lcd_en;
        end
`ifdef LCD_INIT_EN
        chk("init_ready_cycle", c, PWRW + model_busy(0, 8'h38) + model_busy(0, 8'h0C)
                                        + model_busy(0, 8'h01) + model_busy(0, 8'h06));
        chk("init_first_rise", first_rise, PWRW + SETUP);
        chk("init_pulses", seen.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("init_byte", (k < seen.size()) ? int'(seen[k]) : -1, exp_seq[k]);
`else
        chk("ready_after_release", c, 0);
        chk("no_pulse_after_release", seen.size(), 0);
`endif
    endtask

    // Single transfer started at a negedge with ready high; optional garbage requests while busy.
    task automatic xfer(input logic rs, input logic [7:0] d, input bit noise,
                        output int busy, output int en_first, output int en_len, output int bad);
        i_cmd_rs    = rs;
        i_cmd_data  = d;
        i_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        busy = 0; en_first = -1; en_len = 0; bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_cmd_ready) break;
            busy++;
            if (o_lcd_en) begin
                if (en_first < 0) en_first = c;
                en_len++;
            end
            if (o_lcd_data !== d || o_lcd_rs !== rs || o_busy !== 1'b1) bad++;
            if (noise) begin
                i_cmd_valid = 1'($urandom_range(0, 1));
                i_cmd_rs    = 1'($urandom);
                i_cmd_data  = 8'($urandom);
            end
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit noise);
        int busy, en_first, en_len, bad;
        xfer(v.rs, v.data, noise, busy, en_first, en_len, bad);
        chk({tag, "_busy"},     busy, v.busy);
        chk({tag, "_en_first"}, en_first, v.en_first);
        chk({tag, "_en_len"},   en_len, v.en_len);
        chk({tag, "_stable"},   bad, 0);
        chk({tag, "_held_data"}, o_lcd_data, v.data);
        chk({tag, "_held_rs"},   o_lcd_rs, v.rs);
    endtask

    vec_t tbl [7];

    initial begin
        int   c, bad;
        vec_t v;
        logic on_v;

        tbl[0] = '{1'b1, 8'h41, 18, 2, 4};
        tbl[1] = '{1'b0, 8'h01, 48, 2, 4};
        tbl[2] = '{1'b0, 8'h80, 18, 2, 4};
        tbl[3] = '{1'b1, 8'h01, 18, 2, 4};
        tbl[4] = '{1'b0, 8'h02, 48, 2, 4};
        tbl[5] = '{1'b0, 8'h03, 18, 2, 4};
        tbl[6] = '{1'b1, 8'h02, 18, 2, 4};

        i_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd_rs = 1'b0; i_cmd_data = 8'h00; i_lcd_on = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        release_and_wait();

        for (int i = 0; i < 7; i++) run_vec("tbl", tbl[i], bit'(i % 2));

        for (int i = 0; i < 16; i++) begin
            v.rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       v.data = 8'h01;
                1:       v.data = 8'h02;
                default: v.data = 8'($urandom);
            endcase
            v.busy = model_busy(v.rs, v.data);
            v.en_first = SETUP;
            v.en_len = ENC;
            run_vec("rnd", v, bit'($urandom_range(0, 1)));
        end

        // Back-to-back: valid never drops, second byte taken on the first ready cycle.
        i_cmd_rs = 1'b1; i_cmd_data = 8'h48; i_cmd_valid = 1'b1;
        @(posedge clk);
        #1 i_cmd_data = 8'h49;
        bad = 0;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_cmd_ready) break;
            if (o_lcd_data !== 8'h48) bad++;
        end
        chk("b2b_first_busy", c, 18);
        chk("b2b_first_stable", bad, 0);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        chk("b2b_second_data", o_lcd_data, 8'h49);
        chk("b2b_second_ready", o_cmd_ready, 0);
        for (c = 1; c < 200; c++) begin
            @(negedge clk);
            if (o_cmd_ready) break;
        end
        chk("b2b_second_busy", c, model_busy(1, 8'h49));

        // Reset on the second EN-high cycle.
        i_cmd_rs = 1'b1; i_cmd_data = 8'h5A; i_cmd_valid = 1'b1;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_en_before", o_lcd_en, 1);
        i_rst = 1'b0;
        @(negedge clk);
        release_and_wait();

        for (int i = 0; i < 8; i++) begin
            on_v = 1'($urandom);
            i_lcd_on = on_v;
            @(negedge clk);
            chk("lcd_on", o_lcd_on, on_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Consumer side of the CPU's LCD output register: accepts one command/data byte at a time over a valid/ready handshake and generates HD44780-compatible bus timing (RS setup, EN pulse, hold, execution wait).
- Sits between the LSU LCD output path and the board LCD pins.
- Lets firmware write bytes back-to-back without software delay loops; o_cmd_ready is the flow control.

Parameters:
- SETUP_CYC, 2, cycles RS/DATA are stable before EN rises (>=1)
- EN_CYC, 12, EN high width in cycles (>=1)
- HOLD_CYC, 2, cycles RS/DATA are held after EN falls (>=1)
- CMD_WAIT_CYC, 1850, post-hold wait for ordinary commands/data, 37 us at 50 MHz (>=1)
- CLR_WAIT_CYC, 76000, post-hold wait for clear (0x01) and home (0x02) with RS=0, 1.52 ms (>=1)
- PWR_WAIT_CYC, 750000, power-up wait before init, 15 ms; used only with LCD_INIT_EN

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-low reset
- i_cmd_valid  in  1  byte request valid
- o_cmd_ready  out  1  block can accept a byte this cycle
- i_cmd_rs  in  1  0 = instruction, 1 = data
- i_cmd_data  in  8  byte to send
- i_lcd_on  in  1  display power/backlight request
- o_lcd_data  out  8  LCD DB[7:0]
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD RW, constant 0 (write only)
- o_lcd_en  out  1  LCD EN
- o_lcd_on  out  1  registered copy of i_lcd_on
- o_busy  out  1  transfer or wait in progress (= ~o_cmd_ready)

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - Outputs: o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0.
  - Control: o_cmd_ready=0 during reset and 1 from the first cycle after release.
  - State and counter: FSM goes to IDLE and the counter clears. This applies in every state, including mid-pulse: EN drops at that edge.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE: o_cmd_ready=1. On i_cmd_valid&&o_cmd_ready, latch rs/data into o_lcd_rs/o_lcd_data at that edge. Select wait length: CLR_WAIT_CYC if rs=0 and data is 0x01 or 0x02, otherwise CMD_WAIT_CYC. Go to SETUP.
  - SETUP: EN=0 for SETUP_CYC cycles, then PULSE.
  - PULSE: EN=1 for EN_CYC cycles, then HOLD.
  - HOLD: EN=0 for HOLD_CYC cycles, then WAIT.
  - WAIT: EN=0 for the selected wait count, then IDLE.
- Timing and stability:
  - One accepted byte occupies exactly SETUP_CYC+EN_CYC+HOLD_CYC+WAIT cycles after the accept edge before o_cmd_ready returns to 1.
  - o_lcd_rs/o_lcd_data change only at an accept edge and hold their value in all other states, including after returning to IDLE.
  - Requests while not ready are ignored. No buffering; the requester holds valid.
  - i_cmd_valid held high continuously produces back-to-back transfers with no idle gap: a new accept occurs on the first IDLE cycle.
- Counter: a single down-counter, width $clog2(max of all cycle parameters)+1. It loads N-1 on state entry, and the state exits when the counter is 0 (one cycle per count, no off-by-one).
- o_lcd_on: i_lcd_on registered by one cycle, independent of the FSM.

Optional Feature:
- Macro: LCD_INIT_EN.
- Defined:
  - Adds states PWR and INIT, entered from reset instead of IDLE, with o_cmd_ready=0 throughout.
  - PWR waits PWR_WAIT_CYC cycles.
  - INIT then sends 0x38, 0x0C, 0x01, 0x06 (RS=0) through the normal SETUP/PULSE/HOLD/WAIT path. 0x01 uses CLR_WAIT_CYC.
  - After the fourth byte's WAIT, go to IDLE.
- Undefined: reset goes straight to IDLE and firmware performs initialisation.

Decomposition:
- Package lcd_pkg:
  - State enum lcd_state_e.
  - Constants LCD_CMD_CLEAR=8'h01, LCD_CMD_HOME=8'h02, LCD_CMD_FUNC_8B2L=8'h38, LCD_CMD_DISP_ON=8'h0C, LCD_CMD_ENTRY_INC=8'h06.
  - Init sequence array.
- Sub-module lcd_timer: loadable down-counter with load value, load strobe and done flag. Instantiated once.

Test Plan (SETUP=2, EN=4, HOLD=2, CMD_WAIT=10, CLR_WAIT=40, PWR_WAIT=20):
- Data write: valid with rs=1, data=0x41 for one cycle -> RS=1, DATA=0x41 the next cycle; EN high for exactly 4 cycles starting 2 cycles after the accept edge; ready low for exactly 18 cycles.
- Clear vs ordinary: rs=0, 0x01 -> ready low for 48 cycles. rs=0, 0x80 -> 18 cycles. rs=1, 0x01 -> 18 cycles (data, not clear).
- Back-to-back: valid held high with 0x48 then 0x49 -> second accept on the first cycle ready=1. DATA does not change while EN=1 or during HOLD.
- Reset mid-pulse: assert i_rst low on the 2nd EN-high cycle -> EN=0 and DATA=0 at the next edge; ready=1 the cycle after release.
- Ignored request: valid pulsed during WAIT -> no accept, outputs unchanged, no extra EN pulse.
- LCD_INIT_EN: after reset, ready=0. Four EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0. The first pulse rises 20+2 cycles after release. Ready rises after 20+18+18+48+18 = 122 cycles.
